keypad_scanner: RTL and testbench

- Matrix keypad front end that produces the 20-bit key/interrupt vector the CPU register file hardwires into R29.
- Drives active-low rows one at a time and samples active-low columns through a synchronizer.
- Debounces each key independently and exposes two vectors: a debounced level vector, and a sticky press-event vector that software clears.
- Sits between the board keypad pins and the CPU core's interrupt input.

---
 rtl/keypad_scanner.sv | 126 ++++++++++++
 tb/tb_keypad_scanner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks active-low rows, synchronizes columns,
// debounces every key independently and keeps sticky press events.
module keypad_scanner #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 5,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COLS-1:0]      col_n,
  input  logic [ROWS*COLS-1:0] int_clr,
  output logic [ROWS-1:0]      row_n,
  output logic [ROWS*COLS-1:0] key_state,
  output logic [ROWS*COLS-1:0] interrupt,
  output logic                 frame_done
);

  localparam int unsigned KEYS  = ROWS * COLS;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

  logic [COLS-1:0]  r_sync1;
  logic [COLS-1:0]  r_sync2;
  logic [DIV_W-1:0] r_div;
  logic [ROW_W-1:0] r_row;
  logic [ROWS-1:0]  r_row_n;
  logic [CNT_W-1:0] r_cnt [KEYS];
  logic [KEYS-1:0]  r_key_state;
  logic [KEYS-1:0]  r_interrupt;
  logic             r_frame_done;

  logic [COLS-1:0]  w_pressed;
  logic             w_sample;
  logic [ROW_W-1:0] w_row_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [KEYS];
  logic [KEYS-1:0]  w_key_nxt;
  logic [KEYS-1:0]  w_int_nxt;

  assign w_pressed  = ~r_sync2;
  assign w_sample   = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_row_nxt  = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);

  assign row_n      = r_row_n;
  assign key_state  = r_key_state;
  assign interrupt  = r_interrupt;
  assign frame_done = r_frame_done;

  // Two-flop synchronizer on the asynchronous column inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= col_n;
      r_sync2 <= r_sync1;
    end
  end

  // Row dwell divider, row index and row drive; frame pulse after last row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div        <= '0;
      r_row        <= '0;
      r_row_n      <= ~ROWS'(1);
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_sample && (r_row == ROW_W'(ROWS - 1));
      if (w_sample) begin
        r_div   <= '0;
        r_row   <= w_row_nxt;
        r_row_n <= ~(ROWS'(1) << w_row_nxt);
      end else begin
        r_div   <= r_div + DIV_W'(1);
      end
    end
  end

  // Per-key debounce, evaluated only for the active row at its sample point
  always_comb begin
    w_key_nxt = r_key_state;
    for (int k = 0; k < int'(KEYS); k++) begin
      w_cnt_nxt[k] = r_cnt[k];
    end
    if (w_sample) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int c = 0; c < int'(COLS); c++) begin
          if (r_row == ROW_W'(r)) begin
            if (w_pressed[c] == r_key_state[r*COLS+c]) begin
              w_cnt_nxt[r*COLS+c] = '0;
            end else if (r_cnt[r*COLS+c] == CNT_W'(DEBOUNCE - 1)) begin
              w_key_nxt[r*COLS+c] = ~r_key_state[r*COLS+c];
              w_cnt_nxt[r*COLS+c] = '0;
            end else begin
              w_cnt_nxt[r*COLS+c] = r_cnt[r*COLS+c] + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  // Sticky press events: a new press outranks a same-cycle clear
  always_comb begin
    w_int_nxt = (r_interrupt & ~int_clr) | (w_key_nxt & ~r_key_state);
  end

  // Debounce counters, stable key levels and interrupt register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(KEYS); k++) begin
        r_cnt[k] <= '0;
      end
      r_key_state <= '0;
      r_interrupt <= '0;
    end else begin
      for (int k = 0; k < int'(KEYS); k++) begin
        r_cnt[k] <= w_cnt_nxt[k];
      end
      r_key_state <= w_key_nxt;
      r_interrupt <= w_int_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives columns from the held-key
// set; expected output events are queued by the stimulus and checked by a
// monitor whenever the outputs change or a frame completes.
module tb_keypad_scanner;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 5;
  localparam int unsigned KEYS = ROWS * COLS;

  localparam logic [3:0] R0 = 4'b1110;
  localparam logic [3:0] R1 = 4'b1101;
  localparam logic [3:0] R2 = 4'b1011;
  localparam logic [3:0] R3 = 4'b0111;

  typedef struct {
    int              cyc;
    logic [KEYS-1:0] ks;
    logic [KEYS-1:0] intr;
    logic [3:0]      rown;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [COLS-1:0] col_n;
  logic [KEYS-1:0] int_clr;
  logic [ROWS-1:0] row_n;
  logic [KEYS-1:0] key_state;
  logic [KEYS-1:0] interrupt;
  logic            frame_done;

  logic [KEYS-1:0] held;
  int              cyc;
  int              checks;
  int              errors;
  exp_t            exp_q[$];

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(8), .DEBOUNCE(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .col_n(col_n), .int_clr(int_clr),
    .row_n(row_n), .key_state(key_state), .interrupt(interrupt),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycles since the most recent reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Keypad matrix: a held key pulls its column low while its row is driven
  always_comb begin
    col_n = '1;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        if (!row_n[r] && held[r*COLS+c]) col_n[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int c, input logic [KEYS-1:0] k,
                           input logic [KEYS-1:0] i, input logic [3:0] rn);
    exp_t e;
    e.cyc = c; e.ks = k; e.intr = i; e.rown = rn;
    exp_q.push_back(e);
  endtask

  // Monitor: any output change or frame pulse is an event to be matched
  initial begin : monitor
    logic [KEYS-1:0] prev_ks;
    logic [KEYS-1:0] prev_int;
    exp_t            e;
    prev_ks  = '0;
    prev_int = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 &&
          (frame_done === 1'b1 || key_state !== prev_ks || interrupt !== prev_int)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: cyc %0d ks 0x%0h int 0x%0h fd %0b with nothing expected",
                   cyc, key_state, interrupt, frame_done);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", 32'(cyc), 32'(e.cyc));
          check("key_state",   32'(key_state), 32'(e.ks));
          check("interrupt",   32'(interrupt), 32'(e.intr));
          check("row_n",       32'(row_n), 32'(e.rown));
        end
      end
      prev_ks  = key_state;
      prev_int = interrupt;
    end
  end

  task automatic reset_checks();
    check("rst_row_n",      32'(row_n), 32'(R0));
    check("rst_key_state",  32'(key_state), 32'd0);
    check("rst_interrupt",  32'(interrupt), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
  endtask

  initial begin : stimulus
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    held    = 20'h02000;
    int_clr = '0;

    // Bounce (F1-F5), release (F6), press (F7-F9): key 13 debounces at F9 row 2
    expect_ev( 32, 20'h0, 20'h0, R0);
    expect_ev( 64, 20'h0, 20'h0, R0);
    expect_ev( 96, 20'h0, 20'h0, R0);
    expect_ev(128, 20'h0, 20'h0, R0);
    expect_ev(160, 20'h0, 20'h0, R0);
    expect_ev(192, 20'h0, 20'h0, R0);
    expect_ev(224, 20'h0, 20'h0, R0);
    expect_ev(256, 20'h0, 20'h0, R0);
    expect_ev(280, 20'h02000, 20'h02000, R3);
    expect_ev(288, 20'h02000, 20'h02000, R0);
    // Clear key 13 event
    expect_ev(289, 20'h02000, 20'h00000, R0);
    expect_ev(320, 20'h02000, 20'h00000, R0);
    // Key 5 press with a same-cycle clear: set wins
    expect_ev(352, 20'h02000, 20'h00000, R0);
    expect_ev(384, 20'h02000, 20'h00000, R0);
    expect_ev(400, 20'h02020, 20'h00020, R2);
    expect_ev(416, 20'h02020, 20'h00020, R0);
    // Hold keys 0 and 19, release 5 and 13
    expect_ev(448, 20'h02020, 20'h00020, R0);
    expect_ev(480, 20'h02020, 20'h00020, R0);
    expect_ev(488, 20'h02021, 20'h00021, R1);
    expect_ev(496, 20'h02001, 20'h00021, R2);
    expect_ev(504, 20'h00001, 20'h00021, R3);
    expect_ev(512, 20'h80001, 20'h80021, R0);
    // Clear everything
    expect_ev(513, 20'h80001, 20'h00000, R0);
    expect_ev(544, 20'h80001, 20'h00000, R0);
    // Key 7 sampled twice before the mid-run reset
    expect_ev(576, 20'h80001, 20'h00000, R0);
    expect_ev(608, 20'h80001, 20'h00000, R0);

    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    check("row0_dwell", 32'(row_n), 32'(R0));
    @(negedge clk);
    check("row1_after_8", 32'(row_n), 32'(R1));
    repeat (24) @(negedge clk);                 // cyc 32
    repeat (32) @(negedge clk);                 // F2 -> 64
    held = '0;
    repeat (32) @(negedge clk);                 // F3 -> 96
    held = 20'h02000;
    repeat (64) @(negedge clk);                 // F4,F5 -> 160
    held = '0;
    repeat (32) @(negedge clk);                 // F6 -> 192
    held = 20'h02000;
    repeat (96) @(negedge clk);                 // F7-F9 -> 288
    int_clr = 20'h02000;
    @(negedge clk);                             // 289
    int_clr = '0;
    repeat (31) @(negedge clk);                 // 320
    held = 20'h02020;
    repeat (79) @(negedge clk);                 // 399
    int_clr = 20'h00020;
    @(negedge clk);                             // 400
    int_clr = '0;
    repeat (16) @(negedge clk);                 // 416
    held = 20'h80001;
    repeat (96) @(negedge clk);                 // 512
    int_clr = '1;
    @(negedge clk);                             // 513
    int_clr = '0;
    repeat (31) @(negedge clk);                 // 544
    held = 20'h00080;
    repeat (64) @(negedge clk);                 // 608
    repeat (2) @(negedge clk);

    // Reset mid-debounce: key 7 must need three fresh samples
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks();
    check("pre_reset_drained", 32'(exp_q.size()), 32'd0);
    expect_ev(32, 20'h0, 20'h0, R0);
    expect_ev(64, 20'h0, 20'h0, R0);
    expect_ev(80, 20'h00080, 20'h00080, R2);
    expect_ev(96, 20'h00080, 20'h00080, R0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
